// File: rtl/clk_div_sel_if.sv
// clk_div_sel_if
// Groups the control and clock outputs of clk_div_sel into one bundle.
//   mode     [1:0] requested mode: 0 slow, 1 mid, 2 fast, 3 single-step
//   step_btn       raw asynchronous step button, active-high
//   clk_out        generated CPU clock
//   tick           one-cycle enable aligned with each clk_out rising edge
//   mode_cur [1:0] mode currently in effect
// master drives mode/step_btn and observes the outputs; slave is the divider.
interface clk_div_sel_if;
  logic [1:0] mode;
  logic       step_btn;
  logic       clk_out;
  logic       tick;
  logic [1:0] mode_cur;

  modport master (
    output mode,
    output step_btn,
    input  clk_out,
    input  tick,
    input  mode_cur
  );

  modport slave (
    input  mode,
    input  step_btn,
    output clk_out,
    output tick,
    output mode_cur
  );
endinterface

// File: rtl/clk_div_sel.sv
// clk_div_sel
// CPU clock generator: divides clk_in by one of three programmable
// half-periods (slow / mid / fast) or produces single HALF_FAST-wide pulses
// from a step button. Rate changes are applied only when clk_out falls, so
// no runt phase is ever produced. tick is a clk_in-domain enable that is
// high in exactly the cycle clk_out becomes 1.
// Ports:
//   clk_in  board clock, the only clock
//   rst     asynchronous active-high reset
//   bus     clk_div_sel_if.slave (mode, step_btn in; clk_out, tick, mode_cur out)
// Optional feature macro: CLKDIV_DEBOUNCE_EN -- when defined, the synchronised
// step button is debounced over DEB_CYCLES stable cycles before edge detection.
module clk_div_sel #(
  parameter int CNT_W      = 32,
  parameter int HALF_SLOW  = 2500000,
  parameter int HALF_MID   = 250000,
  parameter int HALF_FAST  = 30,
  parameter int DEB_CYCLES = 500000
) (
  input  logic         clk_in,
  input  logic         rst,
  clk_div_sel_if.slave bus
);

  localparam logic [1:0] MODE_STEP = 2'd3;

  localparam logic [CNT_W-1:0] SLOW_M1 = CNT_W'(HALF_SLOW - 1);
  localparam logic [CNT_W-1:0] MID_M1  = CNT_W'(HALF_MID - 1);
  localparam logic [CNT_W-1:0] FAST_M1 = CNT_W'(HALF_FAST - 1);

  // Reject nonsensical configurations at elaboration.
  if (HALF_SLOW < 1 || HALF_MID < 1 || HALF_FAST < 1 || DEB_CYCLES < 1) begin : gBadParams
    $error("clk_div_sel: HALF_SLOW, HALF_MID, HALF_FAST and DEB_CYCLES must be >= 1");
  end

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_STEP_IDLE  = 2'd1,
    ST_STEP_PULSE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       modeCur_q, modeCur_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             clkOut_q, clkOut_d;
  logic             tick_q, tick_d;

  logic             sync1_q, sync2_q;
  logic             btnPrev_q;
  logic             btnLvl;
  logic             stepEdge;
  logic [CNT_W-1:0] halfM1;

  // Two-flop synchroniser for the raw button, plus the previous-level
  // register used by the rising-edge detector.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      btnPrev_q <= 1'b0;
    end else begin
      sync1_q   <= bus.step_btn;
      sync2_q   <= sync1_q;
      btnPrev_q <= btnLvl;
    end
  end

`ifdef CLKDIV_DEBOUNCE_EN
  localparam int DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [DEB_W-1:0] DEB_M1 = DEB_W'(DEB_CYCLES - 1);

  logic             debLevel_q;
  logic [DEB_W-1:0] debCnt_q;

  // The debounced level follows the synchronised button only after the
  // latter has disagreed with it for DEB_CYCLES consecutive cycles; any
  // return to agreement restarts the count.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      debLevel_q <= 1'b0;
      debCnt_q   <= '0;
    end else if (sync2_q == debLevel_q) begin
      debCnt_q   <= '0;
    end else if (debCnt_q == DEB_M1) begin
      debLevel_q <= sync2_q;
      debCnt_q   <= '0;
    end else begin
      debCnt_q   <= debCnt_q + 1'b1;
    end
  end

  assign btnLvl = debLevel_q;
`else
  assign btnLvl = sync2_q;
`endif

  assign stepEdge = btnLvl & ~btnPrev_q;

  // Terminal count for the run mode currently in effect.
  always_comb begin
    case (modeCur_q)
      2'd0:    halfM1 = SLOW_M1;
      2'd1:    halfM1 = MID_M1;
      default: halfM1 = FAST_M1;
    endcase
  end

  // State register for the FSM and all registered outputs.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q   <= ST_RUN;
      modeCur_q <= 2'd0;
      cnt_q     <= '0;
      clkOut_q  <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      modeCur_q <= modeCur_d;
      cnt_q     <= cnt_d;
      clkOut_q  <= clkOut_d;
      tick_q    <= tick_d;
    end
  end

  // Next-state logic. In ST_RUN the counter wraps at H-1 and toggles
  // clk_out; a requested mode is only adopted on the falling toggle so the
  // high phase always finishes at the old rate. In step mode the same
  // counter times the HALF_FAST-wide pulse. A pending mode change out of
  // step mode wins over a coincident step edge.
  always_comb begin
    state_d   = state_q;
    modeCur_d = modeCur_q;
    cnt_d     = cnt_q;
    clkOut_d  = clkOut_q;
    tick_d    = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (cnt_q == halfM1) begin
          cnt_d    = '0;
          clkOut_d = ~clkOut_q;
          tick_d   = ~clkOut_q;
          if (clkOut_q && (bus.mode != modeCur_q)) begin
            modeCur_d = bus.mode;
            if (bus.mode == MODE_STEP) begin
              state_d = ST_STEP_IDLE;
            end
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_STEP_IDLE: begin
        clkOut_d = 1'b0;
        cnt_d    = '0;
        if (bus.mode != MODE_STEP) begin
          modeCur_d = bus.mode;
          state_d   = ST_RUN;
        end else if (stepEdge) begin
          clkOut_d = 1'b1;
          tick_d   = 1'b1;
          state_d  = ST_STEP_PULSE;
        end
      end

      ST_STEP_PULSE: begin
        if (cnt_q == FAST_M1) begin
          clkOut_d = 1'b0;
          cnt_d    = '0;
          state_d  = ST_STEP_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d   = ST_RUN;
        modeCur_d = 2'd0;
        cnt_d     = '0;
        clkOut_d  = 1'b0;
      end
    endcase
  end

  assign bus.clk_out  = clkOut_q;
  assign bus.tick     = tick_q;
  assign bus.mode_cur = modeCur_q;

endmodule

// File: tb/tb_clk_div_sel.sv
// tb_clk_div_sel
// Directed bench for clk_div_sel with HALF_SLOW=8, HALF_MID=4, HALF_FAST=2,
// DEB_CYCLES=4. Each scenario task drives its own stimulus and compares the
// packed vector {clk_out, tick, mode_cur} against hand-derived values one
// cycle at a time. Outputs are sampled 1 time unit after the rising edge.
module tb_clk_div_sel;

  logic clk_in = 1'b0;
  logic rst    = 1'b1;

  int assertCount = 0;
  int failCount   = 0;

  clk_div_sel_if bus ();

  clk_div_sel #(
    .CNT_W      (8),
    .HALF_SLOW  (8),
    .HALF_MID   (4),
    .HALF_FAST  (2),
    .DEB_CYCLES (4)
  ) dut (
    .clk_in (clk_in),
    .rst    (rst),
    .bus    (bus)
  );

  always #5 clk_in = ~clk_in;

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk_in);
    #1;
  endtask

  // Pulse reset for two edges and release it just after an edge; the
  // caller has already set mode.
  task automatic resetDut();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  // Reset, then let one full slow period pass so mode 3 is adopted at the
  // fall after edge 16.
  task automatic enterStep();
    bus.mode     = 2'd3;
    bus.step_btn = 1'b0;
    resetDut();
    repeat (16) cyc();
  endtask

  task automatic test_reset();
    logic [3:0] obs;
    bus.mode     = 2'd0;
    bus.step_btn = 1'b0;
    rst          = 1'b1;
    #2;
    obs = {bus.clk_out, bus.tick, bus.mode_cur};
    assertCount++;
    if (obs !== 4'b0000) begin
      failCount++;
      $display("[TB] FAIL reset_async got %b expected 0000", obs);
    end
    cyc();
    cyc();
    obs = {bus.clk_out, bus.tick, bus.mode_cur};
    assertCount++;
    if (obs !== 4'b0000) begin
      failCount++;
      $display("[TB] FAIL reset_held got %b expected 0000", obs);
    end
    rst = 1'b0;
  endtask

  // Mode 0: 8 low, 8 high, tick on every rise (edge 8, 24, 40).
  task automatic test_mode0();
    logic [3:0] obs, expv;
    bus.mode = 2'd0;
    resetDut();
    for (int k = 1; k <= 40; k++) begin
      cyc();
      obs  = {bus.clk_out, bus.tick, bus.mode_cur};
      expv = {((k / 8) % 2 == 1), (k % 16 == 8), 2'd0};
      assertCount++;
      if (obs !== expv) begin
        failCount++;
        $display("[TB] FAIL mode0 edge %0d got %b expected %b", k, obs, expv);
      end
    end
  endtask

  // Request mode 2 at edge 44, mid high phase; the high phase still ends at
  // edge 48, then 2-cycle phases follow.
  task automatic test_mode_switch();
    logic [3:0] obs, expv;
    int j;
    bus.mode = 2'd0;
    resetDut();
    for (int k = 1; k <= 60; k++) begin
      cyc();
      obs = {bus.clk_out, bus.tick, bus.mode_cur};
      if (k < 48) begin
        expv = {((k / 8) % 2 == 1), (k % 16 == 8), 2'd0};
      end else begin
        j    = k - 48;
        expv = {((j / 2) % 2 == 1), (j % 4 == 2), 2'd2};
      end
      assertCount++;
      if (obs !== expv) begin
        failCount++;
        $display("[TB] FAIL mode_switch edge %0d got %b expected %b", k, obs, expv);
      end
      if (k == 44) bus.mode = 2'd2;
    end
    bus.mode = 2'd0;
  endtask

  // Rate change to mode 1 at the fall of edge 16, then reset asynchronously
  // in the middle of the first mid-rate high phase.
  task automatic test_rst_mid();
    logic [3:0] obs, expv;
    bus.mode = 2'd1;
    resetDut();
    repeat (22) cyc();
    obs = {bus.clk_out, bus.tick, bus.mode_cur};
    assertCount++;
    if (obs !== 4'b1001) begin
      failCount++;
      $display("[TB] FAIL rst_mid_before got %b expected 1001", obs);
    end
    #2;
    rst = 1'b1;
    #1;
    obs = {bus.clk_out, bus.tick, bus.mode_cur};
    assertCount++;
    if (obs !== 4'b0000) begin
      failCount++;
      $display("[TB] FAIL rst_mid_async got %b expected 0000", obs);
    end
    cyc();
    rst = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      cyc();
      obs  = {bus.clk_out, bus.tick, bus.mode_cur};
      expv = {(k >= 8), (k == 8), 2'd0};
      assertCount++;
      if (obs !== expv) begin
        failCount++;
        $display("[TB] FAIL rst_mid_restart edge %0d got %b expected %b", k, obs, expv);
      end
    end
  endtask

`ifndef CLKDIV_DEBOUNCE_EN
  // Button sampled high at E0..E4: clk_out high at E2 and E3, one tick.
  task automatic test_step();
    logic [3:0] obs, expv;
    enterStep();
    for (int i = 0; i < 3; i++) begin
      if (i > 0) cyc();
      obs = {bus.clk_out, bus.tick, bus.mode_cur};
      assertCount++;
      if (obs !== 4'b0011) begin
        failCount++;
        $display("[TB] FAIL step_idle cycle %0d got %b expected 0011", i, obs);
      end
    end
    bus.step_btn = 1'b1;
    for (int i = 0; i <= 10; i++) begin
      cyc();
      obs  = {bus.clk_out, bus.tick, 2'd3};
      obs[1:0] = bus.mode_cur;
      expv = {(i == 2 || i == 3), (i == 2), 2'd3};
      assertCount++;
      if (obs !== expv) begin
        failCount++;
        $display("[TB] FAIL step_pulse E%0d got %b expected %b", i, obs, expv);
      end
      if (i == 4) bus.step_btn = 1'b0;
    end
  endtask

  // Button samples 1,0,1,1,0...: the second rising edge reaches the edge
  // detector while the first pulse is still high and must be dropped.
  task automatic test_back_to_back();
    logic [3:0] obs, expv;
    enterStep();
    bus.step_btn = 1'b1;
    for (int i = 0; i <= 10; i++) begin
      cyc();
      obs  = {bus.clk_out, bus.tick, bus.mode_cur};
      expv = {(i == 2 || i == 3), (i == 2), 2'd3};
      assertCount++;
      if (obs !== expv) begin
        failCount++;
        $display("[TB] FAIL back_to_back E%0d got %b expected %b", i, obs, expv);
      end
      case (i)
        0:       bus.step_btn = 1'b0;
        1:       bus.step_btn = 1'b1;
        3:       bus.step_btn = 1'b0;
        default: ;
      endcase
    end
  endtask

  // Mode change requested while a step pulse is high is held off until the
  // pulse ends (E4) and applied from idle at E5; mode 2 phases follow.
  task automatic test_defer();
    logic [3:0] obs, expv;
    enterStep();
    bus.step_btn = 1'b1;
    for (int i = 0; i <= 9; i++) begin
      cyc();
      obs  = {bus.clk_out, bus.tick, bus.mode_cur};
      expv = {(i == 2 || i == 3 || i == 7 || i == 8), (i == 2 || i == 7),
              (i < 5) ? 2'd3 : 2'd2};
      assertCount++;
      if (obs !== expv) begin
        failCount++;
        $display("[TB] FAIL defer E%0d got %b expected %b", i, obs, expv);
      end
      if (i == 0) bus.step_btn = 1'b0;
      if (i == 2) bus.mode = 2'd2;
    end
  endtask

  // Leave step mode for mode 1 in the same cycle a step edge is detected:
  // the edge is ignored, mode_cur is 1 after one edge, then 4/4 phases.
  task automatic test_leave_step();
    logic [3:0] obs, expv;
    enterStep();
    bus.step_btn = 1'b1;
    cyc();
    cyc();
    obs = {bus.clk_out, bus.tick, bus.mode_cur};
    assertCount++;
    if (obs !== 4'b0011) begin
      failCount++;
      $display("[TB] FAIL leave_before got %b expected 0011", obs);
    end
    bus.mode = 2'd1;
    for (int j = 1; j <= 16; j++) begin
      cyc();
      obs  = {bus.clk_out, bus.tick, bus.mode_cur};
      expv = {(((j - 1) / 4) % 2 == 1), (j == 5 || j == 13), 2'd1};
      assertCount++;
      if (obs !== expv) begin
        failCount++;
        $display("[TB] FAIL leave_step edge %0d got %b expected %b", j, obs, expv);
      end
    end
    bus.step_btn = 1'b0;
  endtask
`else
  // A 3-cycle glitch never reaches the edge detector; a held press gives a
  // pulse at E2+DEB_CYCLES = E6.
  task automatic test_debounce();
    logic [3:0] obs, expv;
    enterStep();
    bus.step_btn = 1'b1;
    for (int i = 0; i <= 11; i++) begin
      cyc();
      obs = {bus.clk_out, bus.tick, bus.mode_cur};
      assertCount++;
      if (obs !== 4'b0011) begin
        failCount++;
        $display("[TB] FAIL debounce_glitch E%0d got %b expected 0011", i, obs);
      end
      if (i == 2) bus.step_btn = 1'b0;
    end
    bus.step_btn = 1'b1;
    for (int i = 0; i <= 10; i++) begin
      cyc();
      obs  = {bus.clk_out, bus.tick, bus.mode_cur};
      expv = {(i == 6 || i == 7), (i == 6), 2'd3};
      assertCount++;
      if (obs !== expv) begin
        failCount++;
        $display("[TB] FAIL debounce_press E%0d got %b expected %b", i, obs, expv);
      end
    end
    bus.step_btn = 1'b0;
  endtask
`endif

  initial begin
    bus.mode     = 2'd0;
    bus.step_btn = 1'b0;
    test_reset();
    test_mode0();
    test_mode_switch();
    test_rst_mid();
`ifndef CLKDIV_DEBOUNCE_EN
    test_step();
    test_back_to_back();
    test_defer();
    test_leave_step();
`else
    test_debounce();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/clk_div_sel.md
# clk_div_sel

Parametrised CPU clock generator, successor to the fixed two-speed divider. It derives the CPU clock from the board clock with three programmable run rates and a button-driven single-step mode. Rate changes take effect only at a period boundary, so the output never produces a runt pulse. It also emits a one-cycle `tick` enable aligned with each CPU clock rising edge, for logic that stays in the `clk_in` domain.

## Interface
Parameters:
- `CNT_W`, 32: counter width; must hold `max(HALF_*)-1`.
- `HALF_SLOW`, 2500000: `clk_in` cycles per half-period in mode 0; must be ≥1.
- `HALF_MID`, 250000: half-period in mode 1; must be ≥1.
- `HALF_FAST`, 30: half-period in mode 2, and high time of a step pulse; must be ≥1.
- `DEB_CYCLES`, 500000: stable cycles required by the debouncer (used only with `CLKDIV_DEBOUNCE_EN`).

Ports:
- `clk_in`  in  1  board clock; the only clock.
- `rst`  in  1  reset; asynchronous, active-high.
- `mode`  in  2  requested mode: 0 slow, 1 mid, 2 fast, 3 single-step. Quasi-static; the block samples it internally.
- `step_btn`  in  1  raw asynchronous step button, active-high.
- `clk_out`  out  1  generated CPU clock, registered.
- `tick`  out  1  one `clk_in`-cycle pulse, registered; asserted in the same cycle `clk_out` becomes 1.
- `mode_cur`  out  2  mode currently in effect.

## Operation
- Reset: `clk_out`=0, `tick`=0, `mode_cur`=0, counter=0, sync/edge/debounce state cleared, no step pulse active. An assertion mid-operation takes effect immediately; after release the block restarts a mode-0 low phase from count 0.
- Run modes (`mode_cur` 0–2), with H = the selected HALF:
  - The counter runs 0..H-1.
  - At count H-1 the counter returns to 0 and `clk_out` toggles.
  - Each phase is therefore exactly H cycles; the period is 2H.
- Mode change from a run mode: the block compares `mode` with `mode_cur` only in the cycle `clk_out` falls (count H-1 with `clk_out`=1).
  - If they differ, `mode_cur`←`mode` in that same cycle.
  - The following low phase uses the new H. The high phase always completes under the old H.
- Step mode (`mode_cur`=3):
  - The counter is idle and `clk_out` is held at 0.
  - `step_btn` passes through a 2-flop synchroniser, then a rising-edge detect.
  - Each detected edge sets `clk_out`=1 and `tick`=1 and starts a pulse.
  - `clk_out` stays high for `HALF_FAST` cycles, then returns to 0.
  - Edges detected while a pulse is active are ignored.
- Leaving step mode: when `mode`≠3, no pulse is active and `clk_out`=0, then `mode_cur`←`mode` and the counter←0. The next low phase starts with the new H.
- Entering step mode: this follows the normal falling-edge rule, so `clk_out` is always 0 on entry.
- Simultaneous events:
  - A step edge in the same cycle `mode_cur` leaves 3 is ignored.
  - A `mode` change during a step pulse is deferred until the pulse ends.

## Timing
- Run-mode latency: `clk_out` rises H cycles after it fell. `tick` is high for exactly 1 cycle per `clk_out` rising edge and never otherwise.
- Step latency:
  - `step_btn` is first sampled high at edge E0.
  - `clk_out` and `tick` go high at E2.
  - `clk_out` falls at E2+`HALF_FAST`.
- Mode-change latency: at most one full period of the old mode (2H cycles).
- `mode_cur` changes only in a cycle where `clk_out` is 0 after the edge.

## Configuration
- `CLKDIV_DEBOUNCE_EN` defined:
  - The synchronised button must hold one level for `DEB_CYCLES` consecutive cycles before the debounced level changes.
  - Edge detection then runs on the debounced level.
  - Step latency becomes E2+`DEB_CYCLES`.
- `CLKDIV_DEBOUNCE_EN` undefined: no debounce logic; edge detection runs directly on the synchroniser output. `DEB_CYCLES` is unused.

## Test plan
All scenarios use HALF_SLOW=8, HALF_MID=4, HALF_FAST=2 and no debounce unless stated.
- Reset then hold `mode`=0: `clk_out` shows 8 cycles low then 8 high, repeating; `tick` fires once every 16 cycles, aligned with each rise; `mode_cur`=0.
- Mode 0 running, switch `mode` to 2 midway through a high phase: the high phase completes at 8 cycles; `mode_cur` becomes 2 at the fall; phases are 2 cycles from then on.
- `mode`=3, then pulse `step_btn` high for 5 cycles: `clk_out` is 1 for exactly 2 cycles starting 2 cycles after the first sample; one `tick`; then held low.
- Step mode, press `step_btn` again 1 cycle after a pulse starts: the second press is ignored; only one 2-cycle pulse occurs.
- Step mode, set `mode`=1: `mode_cur`=1 the next cycle, then 4-low/4-high phases begin.
- Assert `rst` mid high phase in mode 1: `clk_out`, `tick` and `mode_cur` go to 0 asynchronously. With `CLKDIV_DEBOUNCE_EN` and DEB_CYCLES=4, a 3-cycle button glitch produces no pulse.
